spi_target_regfile: RTL and testbench

//  SPI mode-0 target (responder) for the SoC SPI host (spih_*): single-lane MOSI/MISO

---
 rtl/spi_target_regfile.sv | 153 +++++++++++++++
 tb/tb_spi_target_regfile.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_target_regfile.sv
// ---------------------------------------------------------------------------
// spi_target_regfile : SPI mode-0 target with an NumRegs-byte register file
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spi_target_regfile #(
  parameter int unsigned   SyncStages = 2,
  parameter int unsigned   NumRegs    = 16,
  parameter logic [7:0]    IdValue    = 8'hC5,
  localparam int unsigned  AddrWidth  = $clog2(NumRegs)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   spi_sck_i,
  input  logic                   spi_csb_i,
  input  logic                   spi_sd_i,
  output logic                   spi_sd_o,
  output logic                   spi_sd_en_o,
  output logic [NumRegs*8-1:0]   regs_o,
  output logic                   reg_wr_o,
  output logic [AddrWidth-1:0]   reg_wr_addr_o
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StCmd    = 3'd1,
    StAddr   = 3'd2,
    StWrite  = 3'd3,
    StRead   = 3'd4,
    StId     = 3'd5,
    StIgnore = 3'd6
  } state_e;

  logic [SyncStages-1:0]      sck_sync_q, csb_sync_q, sd_sync_q;
  logic                       sck_last_q;
  logic                       sck_s, csb_s, sd_s, sck_rise, sck_fall;

  state_e                     state_q;
  logic                       armed_q;
  logic                       is_wr_q;
  logic [2:0]                 bit_cnt_q;
  logic [6:0]                 rx_q;
  logic [6:0]                 tx_q;
  logic [AddrWidth-1:0]       addr_q;
  logic [NumRegs-1:0][7:0]    regs_q;
  logic [7:0]                 rx_byte;
  logic [7:0]                 tx_load;

  // CSB synchronizer resets low so a transfer already running at reset
  // release cannot arm the FSM until CSB is actually seen high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sck_sync_q <= '0;
      csb_sync_q <= '0;
      sd_sync_q  <= '0;
      sck_last_q <= 1'b0;
    end else begin
      sck_sync_q <= {sck_sync_q[SyncStages-2:0], spi_sck_i};
      csb_sync_q <= {csb_sync_q[SyncStages-2:0], spi_csb_i};
      sd_sync_q  <= {sd_sync_q[SyncStages-2:0], spi_sd_i};
      sck_last_q <= sck_sync_q[SyncStages-1];
    end
  end

  assign sck_s    = sck_sync_q[SyncStages-1];
  assign csb_s    = csb_sync_q[SyncStages-1];
  assign sd_s     = sd_sync_q[SyncStages-1];
  assign sck_rise = sck_s & ~sck_last_q;
  assign sck_fall = ~sck_s & sck_last_q;
  assign rx_byte  = {rx_q, sd_s};
  assign tx_load  = (state_q == StId) ? IdValue : regs_q[addr_q];
  assign regs_o   = regs_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      armed_q       <= 1'b0;
      is_wr_q       <= 1'b0;
      bit_cnt_q     <= '0;
      rx_q          <= '0;
      tx_q          <= '0;
      addr_q        <= '0;
      regs_q        <= '0;
      spi_sd_o      <= 1'b0;
      spi_sd_en_o   <= 1'b0;
      reg_wr_o      <= 1'b0;
      reg_wr_addr_o <= '0;
    end else begin
      reg_wr_o <= 1'b0;
      if (csb_s) begin
        armed_q     <= 1'b1;
        state_q     <= StIdle;
        bit_cnt_q   <= '0;
        spi_sd_o    <= 1'b0;
        spi_sd_en_o <= 1'b0;
      end else begin
        case (state_q)
          StIdle: begin
            if (armed_q && !sck_s) begin
              state_q   <= StCmd;
              bit_cnt_q <= '0;
            end
          end
          StCmd, StAddr, StWrite: begin
            if (sck_rise) begin
              rx_q      <= rx_byte[6:0];
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                if (state_q == StCmd) begin
                  case (rx_byte)
                    8'h02:   begin state_q <= StAddr; is_wr_q <= 1'b1; end
                    8'h03:   begin state_q <= StAddr; is_wr_q <= 1'b0; end
                    8'h9F:   state_q <= StId;
                    default: state_q <= StIgnore;
                  endcase
                end else if (state_q == StAddr) begin
                  addr_q  <= rx_byte[AddrWidth-1:0];
                  state_q <= is_wr_q ? StWrite : StRead;
                end else begin
                  regs_q[addr_q] <= rx_byte;
                  reg_wr_o       <= 1'b1;
                  reg_wr_addr_o  <= addr_q;
                  addr_q         <= addr_q + 1'b1;
                end
              end
            end
          end
          StRead, StId: begin
            // bit_cnt_q == 0 marks a byte boundary: reload the shifter
            if (sck_fall) begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd0) begin
                tx_q        <= tx_load[6:0];
                spi_sd_o    <= tx_load[7];
                spi_sd_en_o <= 1'b1;
                if (state_q == StRead) addr_q <= addr_q + 1'b1;
              end else begin
                tx_q     <= {tx_q[5:0], 1'b0};
                spi_sd_o <= tx_q[6];
              end
            end
          end
          StIgnore: ;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_target_regfile.sv
// ---------------------------------------------------------------------------
// tb_spi_target_regfile : randomized bench against a byte-array reference model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_spi_target_regfile;

  localparam int NR   = 16;
  localparam int HALF = 60;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              sck = 1'b0;
  logic              csb = 1'b1;
  logic              mosi = 1'b0;
  logic              miso, sd_en, wr;
  logic [NR*8-1:0]   regs;
  logic [3:0]        wr_addr;

  always #5 clk = ~clk;

  spi_target_regfile dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .spi_sck_i     (sck),
    .spi_csb_i     (csb),
    .spi_sd_i      (mosi),
    .spi_sd_o      (miso),
    .spi_sd_en_o   (sd_en),
    .regs_o        (regs),
    .reg_wr_o      (wr),
    .reg_wr_addr_o (wr_addr)
  );

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  ref_regs [NR];
  int          wr_log [$];
  logic [7:0]  wdata [$];

  always @(negedge clk) if (wr) wr_log.push_back(int'(wr_addr));

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [NR*8-1:0] ref_vec();
    logic [NR*8-1:0] v;
    for (int i = 0; i < NR; i++) v[8*i +: 8] = ref_regs[i];
    return v;
  endfunction

  // MSB-first mode-0 host: MOSI set while SCK low, MISO/enable sampled at the rise.
  task automatic xfer(input logic [7:0] tx, input int nb, output logic [7:0] rx, output logic [7:0] env);
    rx = '0;
    env = '0;
    for (int b = 7; b > 7 - nb; b--) begin
      mosi = tx[b];
      #HALF;
      sck = 1'b1;
      rx[b] = miso;
      env[b] = sd_en;
      #HALF;
      sck = 1'b0;
    end
  endtask

  task automatic cs_low();
    wr_log.delete();
    csb = 1'b0;
    #HALF;
  endtask

  task automatic cs_high();
    #HALF;
    csb = 1'b1;
    #(HALF * 2);
    check("en_after_cs", {127'd0, sd_en}, 128'd0);
  endtask

  task automatic spi_write(input logic [7:0] a);
    logic [7:0] rx, env;
    int n;
    n = wdata.size();
    cs_low();
    xfer(8'h02, 8, rx, env);
    xfer(a, 8, rx, env);
    for (int i = 0; i < n; i++) begin
      xfer(wdata[i], 8, rx, env);
      ref_regs[(int'(a) + i) % NR] = wdata[i];
    end
    cs_high();
    check("wr_pulses", 128'(wr_log.size()), 128'(n));
    for (int i = 0; i < n && i < wr_log.size(); i++)
      check("wr_addr", 128'(wr_log[i]), 128'((int'(a) + i) % NR));
    check("regs_after_wr", regs, ref_vec());
  endtask

  task automatic spi_read(input logic [7:0] a, input int n);
    logic [7:0] rx, e1, e2;
    cs_low();
    xfer(8'h03, 8, rx, e1);
    xfer(a, 8, rx, e2);
    check("rd_en_hdr", {120'd0, e1 | e2}, 128'd0);
    for (int i = 0; i < n; i++) begin
      xfer(8'h00, 8, rx, e1);
      check("rd_data", {120'd0, rx}, {120'd0, ref_regs[(int'(a) + i) % NR]});
      check("rd_en_data", {120'd0, e1}, {120'd0, 8'hFF});
    end
    cs_high();
    check("rd_no_wr", 128'(wr_log.size()), 128'd0);
  endtask

  task automatic spi_id(input int n);
    logic [7:0] rx, env;
    cs_low();
    xfer(8'h9F, 8, rx, env);
    check("id_en_hdr", {120'd0, env}, 128'd0);
    for (int i = 0; i < n; i++) begin
      xfer(8'($urandom), 8, rx, env);
      check("id_data", {120'd0, rx}, {120'd0, 8'hC5});
      check("id_en_data", {120'd0, env}, {120'd0, 8'hFF});
    end
    cs_high();
    check("id_no_wr", 128'(wr_log.size()), 128'd0);
    check("regs_after_id", regs, ref_vec());
  endtask

  initial begin
    logic [7:0] rx, env;
    for (int i = 0; i < NR; i++) ref_regs[i] = 8'h00;

    #50;
    check("reset_outs", {122'd0, miso, sd_en, wr, 3'd0}, 128'd0);
    check("reset_addr", {124'd0, wr_addr}, 128'd0);
    check("reset_regs", regs, 128'd0);
    #20 rst_n = 1'b1;
    #(HALF * 2);

    // Fixed write burst and read across the wrap point
    wdata = '{8'hA5, 8'h3C};
    spi_write(8'h05);
    wdata = '{8'h11};
    spi_write(8'h0F);
    wdata = '{8'h22};
    spi_write(8'h00);
    spi_read(8'h0F, 2);

    spi_id(3);

    // Abort mid-byte: partial data must be discarded
    cs_low();
    xfer(8'h02, 8, rx, env);
    xfer(8'h03, 8, rx, env);
    xfer(8'hF0, 4, rx, env);
    cs_high();
    check("abort_no_wr", 128'(wr_log.size()), 128'd0);
    check("abort_regs", regs, ref_vec());
    wdata = '{8'h7E};
    spi_write(8'h03);

    // Unknown command is ignored, next command decodes normally
    cs_low();
    xfer(8'h55, 8, rx, env);
    xfer(8'($urandom), 8, rx, rx);
    xfer(8'($urandom), 8, rx, rx);
    check("ign_en", {120'd0, env}, 128'd0);
    cs_high();
    check("ign_no_wr", 128'(wr_log.size()), 128'd0);
    spi_read(8'h03, 1);

    for (int it = 0; it < 14; it++) begin
      int op;
      op = $urandom_range(0, 2);
      if (op == 0) begin
        wdata.delete();
        for (int k = 0; k < $urandom_range(1, 5); k++) wdata.push_back(8'($urandom));
        spi_write(8'($urandom));
      end else if (op == 1) begin
        spi_read(8'($urandom), $urandom_range(1, 4));
      end else begin
        spi_id($urandom_range(1, 2));
      end
    end

    // Reset in the middle of a read with CSB held low afterwards
    cs_low();
    xfer(8'h03, 8, rx, env);
    xfer(8'h00, 8, rx, env);
    xfer(8'h00, 3, rx, env);
    rst_n = 1'b0;
    #1;
    check("midrst_outs", {125'd0, miso, sd_en, wr}, 128'd0);
    check("midrst_regs", regs, 128'd0);
    for (int i = 0; i < NR; i++) ref_regs[i] = 8'h00;
    #20 rst_n = 1'b1;
    #9;
    xfer(8'h00, 5, rx, env);
    xfer(8'h02, 8, rx, env);
    xfer(8'h01, 8, rx, env);
    xfer(8'hAA, 8, rx, env);
    check("midrst_ignored_en", {120'd0, env}, 128'd0);
    cs_high();
    check("midrst_no_wr", 128'(wr_log.size()), 128'd0);
    check("midrst_regs_hold", regs, 128'd0);
    wdata = '{8'h5A};
    spi_write(8'h09);
    spi_read(8'h09, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
